pcileech_gbox_sysctl: RTL and testbench

System-control front end for the GBOX board. It sits directly upstream of the board top's reset, FIFO and PCIe logic, and owns the raw board-level signals: clock-wizard lock, power switch, PCIe present and PERST#. It synchronises and debounces those inputs, sequences the active-high system reset `rst` consumed by com/fifo/pcie, and decodes short and long presses of the power switch. It also drives the PCIe LED, combining the core's link-state indication with a "no card present" blink.

---
 rtl/pcileech_gbox_sysctl_if.sv | 26 ++
 rtl/pcileech_gbox_sysctl.sv | 176 +++++++++++++++++
 tb/tb_pcileech_gbox_sysctl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_gbox_sysctl_if.sv
// Board-level system-control signal bundle between the GBOX pins/PCIe core and the sysctl block.
// The master drives the raw board inputs; the slave (sysctl) drives the conditioned outputs.
interface pcileech_gbox_sysctl_if;
  logic       clk_locked;
  logic       power_sw;
  logic       pcie_present;
  logic       pcie_perst_n;
  logic       led_pcie;
  logic       rst;
  logic       pcie_present_s;
  logic       pcie_perst_n_s;
  logic       sw_press;
  logic       sw_longpress;
  logic       pcie_led;
  logic [1:0] state;

  modport master (
    output clk_locked, power_sw, pcie_present, pcie_perst_n, led_pcie,
    input  rst, pcie_present_s, pcie_perst_n_s, sw_press, sw_longpress, pcie_led, state
  );

  modport slave (
    input  clk_locked, power_sw, pcie_present, pcie_perst_n, led_pcie,
    output rst, pcie_present_s, pcie_perst_n_s, sw_press, sw_longpress, pcie_led, state
  );
endinterface

// File: rtl/pcileech_gbox_sysctl.sv
// GBOX system control: input sync/debounce, rst sequencing, power-switch press decode, PCIe LED.
// Latency: SYNC stages to perst_n_s, SYNC+DEBOUNCE to present/switch; free-running, no backpressure.
module pcileech_gbox_sysctl #(
  parameter int PARAM_SYNC_STAGES       = 2,
  parameter int PARAM_DEBOUNCE_CYCLES   = 625000,
  parameter int PARAM_RST_HOLD_CYCLES   = 64,
  parameter int PARAM_LONGPRESS_CYCLES  = 250000000,
  parameter int PARAM_BLINK_HALF_CYCLES = 31250000
) (
  input logic                   clk,
  input logic                   rst_n,
  pcileech_gbox_sysctl_if.slave sys
);

  localparam int DBW = (PARAM_DEBOUNCE_CYCLES   > 1) ? $clog2(PARAM_DEBOUNCE_CYCLES)   : 1;
  localparam int HW  = (PARAM_RST_HOLD_CYCLES   > 1) ? $clog2(PARAM_RST_HOLD_CYCLES)   : 1;
  localparam int LPW = (PARAM_LONGPRESS_CYCLES  > 1) ? $clog2(PARAM_LONGPRESS_CYCLES)  : 1;
  localparam int BW  = (PARAM_BLINK_HALF_CYCLES > 1) ? $clog2(PARAM_BLINK_HALF_CYCLES) : 1;

  localparam int I_PERST = 0;
  localparam int I_PRES  = 1;
  localparam int I_SW    = 2;
  localparam int I_LOCK  = 3;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SOFTRST = 2'd2
  } state_t;

  logic [PARAM_SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                        raw;
  logic [3:0]                        synced;

  assign raw    = {sys.clk_locked, sys.power_sw, sys.pcie_present, sys.pcie_perst_n};
  assign synced = sync_q[PARAM_SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[PARAM_SYNC_STAGES-2:0], raw};
  end

  // Debounce channels: bit 0 = power switch, bit 1 = card present.
  logic [1:0]     db_in;
  logic [1:0]     db_q;
  logic [1:0]     db_flip;
  logic [DBW-1:0] db_cnt_q [2];

  assign db_in = {synced[I_PRES], synced[I_SW]};

  always_comb begin
    db_flip = '0;
    for (int i = 0; i < 2; i++)
      db_flip[i] = (db_in[i] != db_q[i]) && (db_cnt_q[i] == DBW'(PARAM_DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (db_in[i] == db_q[i] || db_flip[i]) db_cnt_q[i] <= '0;
        else                                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        if (db_flip[i]) db_q[i] <= db_in[i];
      end
    end
  end

  logic sw_db;
  logic pres_db;
  assign sw_db   = db_q[0];
  assign pres_db = db_q[1];

  logic [LPW-1:0] press_cnt_q;
  logic           lp_fired_q;
  logic           press_q;
  logic           longpress_q;
  logic           lp_hit;
  logic           sw_fall;

  assign lp_hit  = sw_db && !lp_fired_q && (press_cnt_q == LPW'(PARAM_LONGPRESS_CYCLES - 1));
  assign sw_fall = sw_db && db_flip[0];

  // A release coinciding with the long-press edge counts as a long press only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt_q <= '0;
      lp_fired_q  <= 1'b0;
      press_q     <= 1'b0;
      longpress_q <= 1'b0;
    end else begin
      longpress_q <= lp_hit;
      press_q     <= sw_fall && !lp_fired_q && !lp_hit;
      if (!sw_db) begin
        press_cnt_q <= '0;
        lp_fired_q  <= 1'b0;
      end else begin
        if (press_cnt_q != LPW'(PARAM_LONGPRESS_CYCLES - 1)) press_cnt_q <= press_cnt_q + LPW'(1);
        if (lp_hit) lp_fired_q <= 1'b1;
      end
    end
  end

  state_t        st_q;
  state_t        st_d;
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic          lock_s;

  assign lock_s = synced[I_LOCK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_HOLD;
      hold_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    hold_cnt_d = '0;
    case (st_q)
      ST_HOLD: begin
        if (lock_s) begin
          if (hold_cnt_q == HW'(PARAM_RST_HOLD_CYCLES - 1)) st_d = ST_RUN;
          else hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s)          st_d = ST_HOLD;
        else if (longpress_q) st_d = ST_SOFTRST;
      end
      ST_SOFTRST: st_d = ST_HOLD;
      default:    st_d = ST_HOLD;
    endcase
  end

  logic          blink_mode;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  logic          led_q;

  assign blink_mode = (st_q == ST_RUN) && !pres_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      led_q <= sys.led_pcie;
      if (!blink_mode) begin
        blink_cnt_q <= '0;
        blink_q     <= 1'b0;
      end else if (blink_cnt_q == BW'(PARAM_BLINK_HALF_CYCLES - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign sys.rst            = (st_q != ST_RUN);
  assign sys.state          = st_q;
  assign sys.pcie_present_s = pres_db;
  assign sys.pcie_perst_n_s = synced[I_PERST];
  assign sys.sw_press       = press_q;
  assign sys.sw_longpress   = longpress_q;
  assign sys.pcie_led       = (st_q == ST_RUN) && (pres_db ? led_q : blink_q);

endmodule

// File: tb/tb_pcileech_gbox_sysctl.sv
// Randomised bench for pcileech_gbox_sysctl: a timestamp-based reference model predicts levels and
// pulse events; a monitor on the falling edge compares DUT outputs against it.
module tb_pcileech_gbox_sysctl;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int H    = 8;
  localparam int L    = 20;
  localparam int B    = 5;
  localparam int MAXT = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pcileech_gbox_sysctl_if sys();

  pcileech_gbox_sysctl #(
    .PARAM_SYNC_STAGES      (SYNC),
    .PARAM_DEBOUNCE_CYCLES  (DB),
    .PARAM_RST_HOLD_CYCLES  (H),
    .PARAM_LONGPRESS_CYCLES (L),
    .PARAM_BLINK_HALF_CYCLES(B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sys  (sys)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp);
    end
  endtask

  // Reference model: t counts clock edges since reset release; index t holds post-edge values.
  typedef struct { int t; int kind; } ev_t;   // kind 1 = press, 2 = long press
  ev_t  exp_q[$];
  int   t;
  logic raw_lock [MAXT];
  logic raw_sw   [MAXT];
  logic raw_pres [MAXT];
  logic raw_perst[MAXT];
  logic syn_lock [MAXT];
  logic syn_sw   [MAXT];
  logic syn_pres [MAXT];
  int   m_db, m_pres, m_state, m_lp, m_press, m_led, m_perst;
  int   hold_run, rise_t, b0, blink_prev;

  task automatic model_reset();
    t = 0;
    syn_lock[0] = 1'b0; syn_sw[0] = 1'b0; syn_pres[0] = 1'b0;
    m_db = 0; m_pres = 0; m_state = 0; m_lp = 0; m_press = 0; m_led = 0; m_perst = 0;
    hold_run = 0; rise_t = 0; b0 = 0; blink_prev = 0;
    exp_q.delete();
  endtask

  // A debounced value adopts the synced value once it has differed for DB consecutive cycles.
  function automatic int deb(input int prev, input int sel);
    logic v;
    if (t < DB) return prev;
    v = (sel == 0) ? syn_sw[t-1] : syn_pres[t-1];
    for (int k = t - DB; k < t; k++)
      if (((sel == 0) ? syn_sw[k] : syn_pres[k]) != v) return prev;
    return int'(v);
  endfunction

  task automatic model_step();
    int p_db, p_state, p_lp, nd, np, blink;
    p_db = m_db; p_state = m_state; p_lp = m_lp;
    t++;
    if (t >= MAXT) begin
      $display("FAIL model_overflow t=%0d limit=%0d", t, MAXT);
      $fatal(1);
    end
    raw_lock[t-1] = sys.clk_locked; raw_sw[t-1] = sys.power_sw;
    raw_pres[t-1] = sys.pcie_present; raw_perst[t-1] = sys.pcie_perst_n;
    syn_lock[t] = (t >= SYNC) ? raw_lock[t-SYNC] : 1'b0;
    syn_sw[t]   = (t >= SYNC) ? raw_sw[t-SYNC]   : 1'b0;
    syn_pres[t] = (t >= SYNC) ? raw_pres[t-SYNC] : 1'b0;
    m_perst     = (t >= SYNC) ? int'(raw_perst[t-SYNC]) : 0;
    nd = deb(p_db, 0);
    np = deb(m_pres, 1);
    m_lp    = (p_db == 1 && (t - rise_t) == L) ? 1 : 0;
    m_press = (p_db == 1 && nd == 0 && (t - rise_t) < L) ? 1 : 0;
    if (nd == 1 && p_db == 0) rise_t = t;
    if (m_lp == 1)    exp_q.push_back('{t, 2});
    if (m_press == 1) exp_q.push_back('{t, 1});
    case (p_state)
      0:       m_state = (hold_run >= H) ? 1 : 0;
      1:       m_state = !syn_lock[t-1] ? 0 : ((p_lp == 1) ? 2 : 1);
      default: m_state = 0;
    endcase
    hold_run = (m_state == 0 && syn_lock[t]) ? hold_run + 1 : 0;
    m_db   = nd;
    m_pres = np;
    blink  = (m_state == 1 && m_pres == 0) ? 1 : 0;
    if (blink == 1 && blink_prev == 0) b0 = t;
    blink_prev = blink;
    if (m_state != 1)    m_led = 0;
    else if (m_pres == 1) m_led = int'(sys.led_pcie);
    else                  m_led = ((t - b0) / B) % 2;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor: level outputs every cycle; pulses scored against the expected-event queue.
  initial begin
    forever begin
      int dut_kind, exp_kind;
      @(negedge clk);
      chk("rst",            int'(sys.rst),            (m_state != 1) ? 1 : 0);
      chk("state",          int'(sys.state),          m_state);
      chk("pcie_led",       int'(sys.pcie_led),       m_led);
      chk("pcie_present_s", int'(sys.pcie_present_s), m_pres);
      chk("pcie_perst_n_s", int'(sys.pcie_perst_n_s), m_perst);
      dut_kind = int'(sys.sw_press) + 2 * int'(sys.sw_longpress);
      if (dut_kind != 0 || (exp_q.size() > 0 && exp_q[0].t <= t)) begin
        exp_kind = 0;
        if (exp_q.size() > 0 && exp_q[0].t <= t) exp_kind = exp_q.pop_front().kind;
        chk("sw_pulse", dut_kind, exp_kind);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 sys.led_pcie = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) sys.pcie_perst_n = ~sys.pcie_perst_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    sys.clk_locked   = 1'b1;
    sys.power_sw     = 1'b0;
    sys.pcie_present = 1'b1;
    sys.pcie_perst_n = 1'b1;
    sys.led_pcie     = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(30);

    for (int i = 0; i < 3; i++) begin
      sys.clk_locked = 1'b0;
      tick((i == 0) ? 3 : $urandom_range(1, 6));
      sys.clk_locked = 1'b1;
      tick(20);
    end

    for (int i = 0; i < 3; i++) begin
      sys.power_sw = 1'b1;
      tick($urandom_range(1, DB - 1));
      sys.power_sw = 1'b0;
      tick(10);
      sys.power_sw = 1'b1;
      tick((i == 0) ? 10 : $urandom_range(DB + 1, L - 2));
      sys.power_sw = 1'b0;
      tick(15);
    end

    sys.power_sw = 1'b1;
    tick(40);
    sys.power_sw = 1'b0;
    tick(30);

    sys.pcie_present = 1'b0;
    tick(40);
    sys.pcie_present = 1'b1;
    tick(2);
    sys.pcie_present = 1'b0;
    tick(1);
    sys.pcie_present = 1'b1;
    tick(25);

    // Asynchronous reset while blinking with a long press in progress.
    sys.pcie_present = 1'b0;
    tick(12);
    sys.power_sw = 1'b1;
    tick(14);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rst",          int'(sys.rst),            1);
    chk("arst_state",        int'(sys.state),          0);
    chk("arst_led",          int'(sys.pcie_led),       0);
    chk("arst_press",        int'(sys.sw_press),       0);
    chk("arst_longpress",    int'(sys.sw_longpress),   0);
    chk("arst_present_s",    int'(sys.pcie_present_s), 0);
    chk("arst_perst_n_s",    int'(sys.pcie_perst_n_s), 0);
    sys.power_sw = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(30);
    sys.pcie_present = 1'b1;
    tick(20);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) sys.clk_locked   = ~sys.clk_locked;
      else if (!sys.clk_locked && $urandom_range(0, 3) == 0) sys.clk_locked = 1'b1;
      if ($urandom_range(0, 5) == 0)   sys.power_sw     = ~sys.power_sw;
      if ($urandom_range(0, 29) == 0)  sys.power_sw     = 1'b1;
      if ($urandom_range(0, 11) == 0)  sys.pcie_present = ~sys.pcie_present;
      tick(($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : 1);
    end

    sys.power_sw = 1'b0;
    tick(L + 20);
    chk("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
